median_window_gen: RTL and testbench

- Upstream stage of the median filter. Accepts a raster-order pixel stream, buffers the two previous image lines, and forms 3x3 neighbourhoods.
- Presents each valid-interior 3x3 window as nine parallel values to bubble_sort_unit, with a one-cycle start pulse.
- Stalls the pixel stream until the sorter reports completion, so only one window is ever in flight.

---
 rtl/median_window_gen_pkg.sv | 19 +
 rtl/median_window_gen_line_buffer.sv | 27 ++
 rtl/median_window_gen.sv | 159 +++++++++++++++
 tb/tb_median_window_gen.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/median_window_gen_pkg.sv
// Shared constants and state encoding for the median-filter window generator.
package median_window_gen_pkg;

  // Default pixel width. The top level exposes it as the BIT_WIDTH parameter.
  localparam int PIX_WIDTH_DEF = 8;

  // Number of taps in a 3x3 neighbourhood.
  localparam int WIN_TAPS = 9;

  // FILL : accepting pixels, shifting the window
  // ISSUE: one-cycle start pulse to the sorter
  // WAIT : stalled until the sorter's done rises
  typedef enum logic [1:0] {
    FILL  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } win_state_e;

endpackage

// File: rtl/median_window_gen_line_buffer.sv
// One image line of storage. The read is combinational, so a write to the
// address being read returns the old contents in the same cycle.
module median_window_gen_line_buffer #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic [AW-1:0]    addr,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Old data is presented until the write lands on the clock edge.
  assign rd_data = mem_q[addr];

  // Storage is intentionally not reset; rows 0-1 refill it every frame.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[addr] <= wr_data;
    end
  end

endmodule

// File: rtl/median_window_gen.sv
// Forms 3x3 neighbourhoods from a raster pixel stream and hands each interior
// window to the sorter, stalling the stream until the sorter finishes.
//
// state | meaning
// FILL  | pixels accepted; window and line buffers shift on each transfer
// ISSUE | win_start_o high for one cycle, stream stalled
// WAIT  | stream stalled until a fresh 0->1 edge on sort_done_i
module median_window_gen
  import median_window_gen_pkg::*;
#(
  parameter int BIT_WIDTH  = PIX_WIDTH_DEF,
  parameter int IMG_WIDTH  = 8,
  parameter int IMG_HEIGHT = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 pix_valid_i,
  input  logic [BIT_WIDTH-1:0] pix_data_i,
  output logic                 pix_ready_o,
  input  logic                 sort_done_i,
  output logic                 win_start_o,
  output logic [BIT_WIDTH-1:0] win0_o,
  output logic [BIT_WIDTH-1:0] win1_o,
  output logic [BIT_WIDTH-1:0] win2_o,
  output logic [BIT_WIDTH-1:0] win3_o,
  output logic [BIT_WIDTH-1:0] win4_o,
  output logic [BIT_WIDTH-1:0] win5_o,
  output logic [BIT_WIDTH-1:0] win6_o,
  output logic [BIT_WIDTH-1:0] win7_o,
  output logic [BIT_WIDTH-1:0] win8_o,
  output logic                 frame_done_o
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);

  win_state_e           state_q, state_d;
  logic [CW-1:0]        col_q, col_d;
  logic [RW-1:0]        row_q, row_d;
  logic                 done_prev_q, done_prev_d;
  logic                 frame_done_q, frame_done_d;
  logic [BIT_WIDTH-1:0] win_q [WIN_TAPS];
  logic [BIT_WIDTH-1:0] win_d [WIN_TAPS];

  logic                 xfer;
  logic                 done_edge;
  logic                 last_col;
  logic                 last_row;
  logic [BIT_WIDTH-1:0] lb0_rd;
  logic [BIT_WIDTH-1:0] lb1_rd;

  // Ready is forced low during reset even though state is already FILL.
  assign pix_ready_o = (state_q == FILL) && !RST;
  assign win_start_o = (state_q == ISSUE);
  assign frame_done_o = frame_done_q;

  assign xfer      = pix_valid_i && pix_ready_o;
  assign done_edge = sort_done_i && !done_prev_q;
  assign last_col  = (col_q == CW'(IMG_WIDTH - 1));
  assign last_row  = (row_q == RW'(IMG_HEIGHT - 1));

  assign win0_o = win_q[0];
  assign win1_o = win_q[1];
  assign win2_o = win_q[2];
  assign win3_o = win_q[3];
  assign win4_o = win_q[4];
  assign win5_o = win_q[5];
  assign win6_o = win_q[6];
  assign win7_o = win_q[7];
  assign win8_o = win_q[8];

  // lb0 holds the previous line, lb1 the line before it.
  median_window_gen_line_buffer #(
    .DEPTH (IMG_WIDTH),
    .WIDTH (BIT_WIDTH)
  ) u_lb0 (
    .clk     (CLK),
    .addr    (col_q),
    .wr_en   (xfer),
    .wr_data (pix_data_i),
    .rd_data (lb0_rd)
  );

  median_window_gen_line_buffer #(
    .DEPTH (IMG_WIDTH),
    .WIDTH (BIT_WIDTH)
  ) u_lb1 (
    .clk     (CLK),
    .addr    (col_q),
    .wr_en   (xfer),
    .wr_data (lb0_rd),
    .rd_data (lb1_rd)
  );

  // Next-state, raster counters and window shift.
  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    done_prev_d  = sort_done_i;
    frame_done_d = 1'b0;
    win_d        = win_q;

    case (state_q)
      FILL: begin
        if (xfer && (row_q >= RW'(2)) && (col_q >= CW'(2))) begin
          state_d = ISSUE;
        end
      end
      ISSUE:   state_d = WAIT;
      WAIT: begin
        if (done_edge) begin
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase

    if (xfer) begin
      for (int r = 0; r < 3; r++) begin
        win_d[r*3+0] = win_q[r*3+1];
        win_d[r*3+1] = win_q[r*3+2];
      end
      win_d[2] = lb1_rd;
      win_d[5] = lb0_rd;
      win_d[8] = pix_data_i;

      if (last_col) begin
        col_d = '0;
        row_d = last_row ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
      frame_done_d = last_col && last_row;
    end
  end

  // State, counters and window registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= FILL;
      col_q        <= '0;
      row_q        <= '0;
      done_prev_q  <= 1'b0;
      frame_done_q <= 1'b0;
      for (int i = 0; i < WIN_TAPS; i++) begin
        win_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      done_prev_q  <= done_prev_d;
      frame_done_q <= frame_done_d;
      win_q        <= win_d;
    end
  end

endmodule

// File: tb/tb_median_window_gen.sv
// Bench for median_window_gen on a 4x4 image with a latency-based sorter model.
module tb_median_window_gen;

  localparam int W   = 4;
  localparam int H   = 4;
  localparam int BW  = 8;
  localparam int LAT = 10;

  logic          CLK = 1'b0;
  logic          RST;
  logic          pix_valid_i;
  logic [BW-1:0] pix_data_i;
  logic          pix_ready_o;
  logic          sort_done_i;
  logic          win_start_o;
  logic [BW-1:0] win [9];
  logic          frame_done_o;

  logic [BW-1:0] img [W*H];
  int            n_vec = 0;
  int            n_err = 0;

  always #5 CLK = ~CLK;

  median_window_gen #(
    .BIT_WIDTH  (BW),
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .pix_valid_i  (pix_valid_i),
    .pix_data_i   (pix_data_i),
    .pix_ready_o  (pix_ready_o),
    .sort_done_i  (sort_done_i),
    .win_start_o  (win_start_o),
    .win0_o       (win[0]),
    .win1_o       (win[1]),
    .win2_o       (win[2]),
    .win3_o       (win[3]),
    .win4_o       (win[4]),
    .win5_o       (win[5]),
    .win6_o       (win[6]),
    .win7_o       (win[7]),
    .win8_o       (win[8]),
    .frame_done_o (frame_done_o)
  );

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [71:0] pack9(input logic [BW-1:0] v [9]);
    logic [71:0] p;
    for (int i = 0; i < 9; i++) p[71-8*i -: 8] = v[i];
    return p;
  endfunction

  function automatic logic [BW-1:0] med9(input logic [BW-1:0] v [9]);
    logic [BW-1:0] s [9];
    logic [BW-1:0] t;
    s = v;
    for (int i = 0; i < 9; i++)
      for (int j = 0; j < 8 - i; j++)
        if (s[j] > s[j+1]) begin
          t = s[j]; s[j] = s[j+1]; s[j+1] = t;
        end
    return s[4];
  endfunction

  // Drives one frame from img; entered and left in the low clock phase.
  task automatic run_frame(input bit held, input bit rnd, input int gap_pct, input int rst_win);
    int npix, widx, sort_cnt, budget, wait_cyc, pos, wr, wc;
    bit busy, exp_start, exp_fd, rel, acc;
    logic [BW-1:0] ew  [9];
    logic [BW-1:0] cap [9];

    for (int i = 0; i < W*H; i++) img[i] = rnd ? BW'($urandom) : BW'(i + 1);
    npix = 0; widx = 0; sort_cnt = -1; budget = 0; wait_cyc = 0;
    busy = 0; exp_start = 0; exp_fd = 0;
    for (int i = 0; i < 9; i++) cap[i] = '0;

    while (!(npix == W*H && !busy)) begin
      if (budget >= 3000) break;
      budget++;

      chk("pix_ready", 80'(pix_ready_o), 80'(!busy));
      chk("win_start", 80'(win_start_o), 80'(exp_start));
      chk("frame_done", 80'(frame_done_o), 80'(exp_fd));

      if (exp_start) begin
        pos = npix - 1;
        wr  = pos / W;
        wc  = pos % W;
        for (int k = 0; k < 9; k++) ew[k] = img[(wr - 2 + k/3)*W + (wc - 2 + k%3)];
        chk("window", 80'(pack9(win)), 80'(pack9(ew)));
        chk("median", 80'(med9(win)), 80'(med9(ew)));
        cap = ew;
        widx++;
        wait_cyc = 0;
        sort_cnt = LAT;
      end else if (busy) begin
        chk("window_hold", 80'(pack9(win)), 80'(pack9(cap)));
        wait_cyc++;
      end

      if (rst_win >= 0 && busy && !exp_start && (widx - 1) == rst_win && wait_cyc == 3) begin
        RST = 1'b1;
        pix_valid_i = 1'b0;
        sort_done_i = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        chk("rst_ready", 80'(pix_ready_o), 80'(0));
        chk("rst_start", 80'(win_start_o), 80'(0));
        chk("rst_fdone", 80'(frame_done_o), 80'(0));
        chk("rst_window", 80'(pack9(win)), 80'(0));
        RST = 1'b0;
        #1;
        chk("rst_release_ready", 80'(pix_ready_o), 80'(1));
        return;
      end

      rel = 0;
      if (sort_cnt > 1) begin
        if (!held) sort_done_i = 1'b0;
        sort_cnt--;
      end else if (sort_cnt == 1) begin
        sort_done_i = 1'b0;
        sort_cnt = 0;
      end else if (sort_cnt == 0) begin
        sort_done_i = 1'b1;
        sort_cnt = -1;
        rel = 1;
      end else if (!held) begin
        sort_done_i = 1'b0;
      end

      if (npix < W*H && $urandom_range(0, 99) >= gap_pct) begin
        pix_valid_i = 1'b1;
        pix_data_i  = img[npix];
      end else begin
        pix_valid_i = 1'b0;
        pix_data_i  = BW'($urandom);
      end
      acc = pix_valid_i && !busy;

      @(posedge CLK);
      exp_start = 0;
      exp_fd = 0;
      if (rel) busy = 0;
      if (acc) begin
        wr = npix / W;
        wc = npix % W;
        npix++;
        if (wr >= 2 && wc >= 2) begin
          busy = 1;
          exp_start = 1;
        end
        if (npix == W*H) exp_fd = 1;
      end
      @(negedge CLK);
    end

    chk("frame_timeout", 80'(budget < 3000), 80'(1));
    chk("window_count", 80'(widx), 80'((W-2)*(H-2)));
  endtask

  initial begin
    RST = 1'b1;
    pix_valid_i = 1'b0;
    pix_data_i = '0;
    sort_done_i = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    chk("reset_ready", 80'(pix_ready_o), 80'(0));
    chk("reset_start", 80'(win_start_o), 80'(0));
    chk("reset_fdone", 80'(frame_done_o), 80'(0));
    chk("reset_window", 80'(pack9(win)), 80'(0));
    RST = 1'b0;
    #1;
    chk("reset_release_ready", 80'(pix_ready_o), 80'(1));

    run_frame(1'b0, 1'b0, 0, -1);
    run_frame(1'b1, 1'b0, 0, -1);
    run_frame(1'b0, 1'b0, 0, 0);
    run_frame(1'b0, 1'b0, 0, -1);
    run_frame(1'b0, 1'b1, 30, -1);
    run_frame(1'b1, 1'b1, 30, -1);
    run_frame(1'b0, 1'b1, 50, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
